// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types, FP32 constants and class decode for the FP divider issue queue
package fp_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_WAIT_Z = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'hFFC00000;
    localparam logic [31:0] PINF    = 32'h7F800000;

    localparam int FLAG_NAN    = 3;
    localparam int FLAG_INF    = 2;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_DENORM = 0;

    function automatic logic [3:0] fp_class(input logic [31:0] z);
        logic [7:0]  e;
        logic [22:0] m;
        logic [3:0]  f;
        e = z[30:23];
        m = z[22:0];
        f = '0;
        f[FLAG_NAN]    = (e == EXP_MAX) && (m != '0);
        f[FLAG_INF]    = (e == EXP_MAX) && (m == '0);
        f[FLAG_ZERO]   = (e == '0) && (m == '0);
        f[FLAG_DENORM] = (e == '0) && (m != '0);
        return f;
    endfunction

endpackage

// File: rtl/fp_pair_fifo.sv
// rtl/fp_pair_fifo.sv - synchronous FIFO holding {tag,b,a} operand pairs
module fp_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Caller guarantees push only when not full and pop only when not empty.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fp_div_issue_queue.sv
// rtl/fp_div_issue_queue.sv - buffers tagged FP32 operand pairs and sequences one divider operation at a time
module fp_div_issue_queue
    import fp_div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      div_a,
    output logic             div_a_stb,
    input  logic             div_a_ack,
    output logic [31:0]      div_b,
    output logic             div_b_stb,
    input  logic             div_b_ack,
    input  logic [31:0]      div_z,
    input  logic             div_z_stb,
    output logic             div_z_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    localparam int PW = TAG_W + 64;

    state_t               state;
    state_t               state_nx;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [$clog2(DEPTH):0] count;
    logic [PW-1:0]        head;
    logic [TAG_W-1:0]     cur_tag;

    assign in_ready = (count != ($clog2(DEPTH)+1)'(DEPTH));
    assign push     = in_valid && !full;
    // The head leaves the FIFO once B is taken; the tag rides along in cur_tag.
    assign pop      = (state == ST_SEND_B) && div_b_ack;

    fp_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_tag, in_b, in_a}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (!empty)    state_nx = ST_SEND_A;
            ST_SEND_A: if (div_a_ack) state_nx = ST_SEND_B;
            ST_SEND_B: if (div_b_ack) state_nx = ST_WAIT_Z;
            ST_WAIT_Z: if (div_z_stb) state_nx = ST_OUT;
            ST_OUT:    if (out_ready) state_nx = empty ? ST_IDLE : ST_SEND_A;
            default:                  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= ST_IDLE;
            cur_tag   <= '0;
            out_z     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
            ops_done  <= '0;
        end else begin
            state <= state_nx;
            if (pop) cur_tag <= head[PW-1:64];
            if ((state == ST_WAIT_Z) && div_z_stb) begin
                out_z     <= div_z;
                out_tag   <= cur_tag;
                out_flags <= fp_class(div_z);
            end
            if ((state == ST_OUT) && out_ready) ops_done <= ops_done + 1'b1;
        end
    end

    assign div_a_stb = (state == ST_SEND_A);
    assign div_b_stb = (state == ST_SEND_B);
    assign div_z_ack = (state == ST_WAIT_Z);
    assign out_valid = (state == ST_OUT);
    assign div_a     = div_a_stb ? head[31:0]  : '0;
    assign div_b     = div_b_stb ? head[63:32] : '0;
    assign busy      = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_fp_div_issue_queue.sv
// tb/tb_fp_div_issue_queue.sv - self-checking bench with divider responder and scoreboard reference
module tb_fp_div_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      div_a;
    logic             div_a_stb;
    logic             div_a_ack;
    logic [31:0]      div_b;
    logic             div_b_stb;
    logic             div_b_ack;
    logic [31:0]      div_z;
    logic             div_z_stb;
    logic             div_z_ack;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_z;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    fp_div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
        .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
        .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_tag(out_tag),
        .out_flags(out_flags), .busy(busy), .ops_done(ops_done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } pair_t;

    int               checks = 0;
    int               failures = 0;
    pair_t            exp_q[$];
    logic [CNT_W-1:0] exp_done;
    logic [31:0]      last_z;
    logic [TAG_W-1:0] last_tag;
    logic [3:0]       last_flags;
    bit               stall, hold_b, spur_req, rand_ready;
    int               dly_max;

    logic             p_ov, p_or, p_as, p_aack, p_bs, p_back;
    logic [31:0]      p_z, p_a, p_b;
    logic [TAG_W-1:0] p_tag;
    logic [3:0]       p_flags;

    // Stand-in divider: the quotient only has to be a known function of the operands.
    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40400000 && b == 32'h40000000) return 32'h3FC00000;
        if (a == 32'h00800000 && b == 32'h40000000) return 32'h00400000;
        if (b == 32'h0 && a == 32'h0) return 32'hFFC00000;
        if (b == 32'h0) return {a[31], 31'h7F800000};
        return a ^ {b[7:0], b[31:8]};
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] z);
        int unsigned e, m;
        e = (z >> 23) & 32'hFF;
        m = z & 32'h7FFFFF;
        return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m == 0, e == 0 && m != 0};
    endfunction

    function automatic int pick();
        return (dly_max == 0) ? 0 : int'($urandom_range(0, dly_max));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_snap();
        p_ov = 0; p_or = 0; p_as = 0; p_aack = 0; p_bs = 0; p_back = 0;
        p_z = 0; p_a = 0; p_b = 0; p_tag = 0; p_flags = 0;
    endtask

    // Observe the current cycle, then advance to the next sample point.
    task automatic step();
        pair_t e;
        logic [31:0] ez;
        if (Rst && in_valid && in_ready) exp_q.push_back('{a: in_a, b: in_b, tag: in_tag});
        if (Rst && out_valid && out_ready) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ez = quot(e.a, e.b);
                check("out_z", out_z, ez);
                check("out_tag", out_tag, e.tag);
                check("out_flags", out_flags, ref_flags(ez));
                check("ops_done_at_out", ops_done, exp_done);
            end
            exp_done++;
            last_z = out_z; last_tag = out_tag; last_flags = out_flags;
        end
        if (p_ov && !p_or) check("out_hold", {out_valid, out_z, out_tag, out_flags}, {1'b1, p_z, p_tag, p_flags});
        if (p_as && !p_aack) check("a_hold", {div_a_stb, div_a}, {1'b1, p_a});
        if (p_as && p_aack) check("a_drop", div_a_stb, 1'b0);
        if (p_bs && !p_back) check("b_hold", {div_b_stb, div_b}, {1'b1, p_b});
        if (p_bs && p_back) check("b_drop", div_b_stb, 1'b0);
        p_ov = out_valid; p_or = out_ready; p_z = out_z; p_tag = out_tag; p_flags = out_flags;
        p_as = div_a_stb; p_aack = div_a_ack; p_a = div_a;
        p_bs = div_b_stb; p_back = div_b_ack; p_b = div_b;
        @(negedge Clk); #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        logic acc;
        acc = 0;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1;
        for (int k = 0; k < 300; k++) begin
            acc = in_ready;
            step();
            if (acc) break;
        end
        in_valid = 0;
        check("push_accept", acc, 1'b1);
    endtask

    task automatic drain(input int bound);
        logic done;
        done = 0;
        for (int k = 0; k < bound; k++) begin
            if (exp_q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
            step();
        end
        check("drain_done", done, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, {in_ready, div_a_stb, div_b_stb, div_z_ack, out_valid, busy}, 6'b100000);
        check({tag, "_ops"}, {div_a, div_b}, 64'd0);
        check({tag, "_out"}, {out_z, out_tag, out_flags}, 64'd0);
        check({tag, "_cnt"}, ops_done, 64'd0);
    endtask

    function automatic logic [31:0] rand_b();
        return ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
    endfunction

    // Divider responder, acting on the falling edge.
    initial begin
        int ph, cnt;
        logic [31:0] ga, gb;
        div_a_ack = 0; div_b_ack = 0; div_z_stb = 0; div_z = 0;
        ph = 0; cnt = 0; ga = 0; gb = 0;
        forever begin
            @(negedge Clk);
            div_a_ack = 0;
            div_b_ack = 0;
            if (!Rst) begin
                ph = 0; cnt = 0; div_z_stb = 0; div_z = 0;
            end else begin
                case (ph)
                    0: if (spur_req) begin
                           div_z = 32'h3F800000; div_z_stb = 1; ph = 5;
                       end else if (div_a_stb && !stall) begin
                           if (cnt > 0) cnt--;
                           else begin div_a_ack = 1; ga = div_a; ph = 1; cnt = pick(); end
                       end
                    1: if (div_b_stb && !stall && !hold_b) begin
                           if (cnt > 0) cnt--;
                           else begin div_b_ack = 1; gb = div_b; ph = 2; cnt = pick(); end
                       end
                    2: if (cnt > 0) cnt--;
                       else begin
                           div_z = quot(ga, gb); div_z_stb = 1;
                           ph = div_z_ack ? 4 : 3;
                       end
                    3: if (div_z_ack) ph = 4;
                    4: begin div_z_stb = 0; ph = 0; cnt = pick(); end
                    5: begin div_z_stb = 0; ph = 0; end
                    default: ph = 0;
                endcase
            end
        end
    end

    initial begin
        logic seen;
        Rst = 0; in_valid = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 0;
        stall = 0; hold_b = 0; spur_req = 0; rand_ready = 0; dly_max = 0;
        exp_done = 0; last_z = 0; last_tag = 0; last_flags = 0;
        clear_snap();
        repeat (2) @(negedge Clk);
        #1;
        check_idle_outputs("reset");
        Rst = 1;
        step();

        // Reset while parked in SEND_B.
        hold_b = 1;
        push(32'h40400000, 32'h40000000, 4'd1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (div_b_stb) begin seen = 1; break; end
            step();
        end
        check("reach_send_b", seen, 1'b1);
        check("send_b_operand", div_b, 32'h40000000);
        Rst = 0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        exp_done = 0;
        clear_snap();
        @(negedge Clk); #1;
        Rst = 1; hold_b = 0;
        step();

        // Single operation with latency check.
        out_ready = 1;
        push(32'h40400000, 32'h40000000, 4'd5);
        check("lat_n1", div_a_stb, 1'b0);
        step();
        check("lat_n2", div_a_stb, 1'b1);
        check("lat_n2_a", div_a, 32'h40400000);
        drain(100);
        check("t2_z", last_z, 32'h3FC00000);
        check("t2_tag", last_tag, 4'd5);
        check("t2_flags", last_flags, 4'b0000);
        check("t2_ops", ops_done, 16'd1);

        // Stalled divider: FIFO fills, fifth pair waits.
        stall = 1;
        for (int i = 0; i < 4; i++) push($urandom, rand_b(), 4'(i));
        check("full_ready", in_ready, 1'b0);
        in_a = $urandom; in_b = rand_b(); in_tag = 4'd4; in_valid = 1;
        repeat (5) step();
        check("full_hold_ready", in_ready, 1'b0);
        check("fifth_waits", exp_q.size(), 64'd4);
        stall = 0;
        push(in_a, in_b, 4'd4);
        drain(300);
        check("t3_ops", ops_done, exp_done);

        // Downstream back-pressure in OUT.
        out_ready = 0;
        push($urandom, rand_b(), 4'd9);
        push($urandom, rand_b(), 4'd10);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid) begin seen = 1; break; end
            step();
        end
        check("t4_out_valid", seen, 1'b1);
        for (int k = 0; k < 10; k++) begin
            check("t4_no_issue", {out_valid, div_a_stb}, 2'b10);
            step();
        end
        out_ready = 1;
        step();
        check("t4_next_issue", div_a_stb, 1'b1);
        drain(100);

        // Special-value classification.
        push(32'h3F800000, 32'h00000000, 4'd1);
        drain(100);
        check("inf_z", last_z, 32'h7F800000);
        check("inf_flags", last_flags, 4'b0100);
        push(32'h00000000, 32'h00000000, 4'd2);
        drain(100);
        check("nan_z", last_z, 32'hFFC00000);
        check("nan_flags", last_flags, 4'b1000);
        push(32'h00800000, 32'h40000000, 4'd3);
        drain(100);
        check("den_z", last_z, 32'h00400000);
        check("den_flags", last_flags, 4'b0001);

        // Stray quotient strobe while idle.
        spur_req = 1;
        step();
        spur_req = 0;
        check("spur_no_ack", {div_z_stb, div_z_ack}, 2'b10);
        for (int k = 0; k < 5; k++) begin
            check("spur_no_out", {out_valid, busy}, 2'b00);
            step();
        end
        check("spur_ops", ops_done, exp_done);

        // Randomized traffic with variable divider and downstream timing.
        dly_max = 3;
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            push($urandom, rand_b(), 4'($urandom));
        end
        drain(3000);
        rand_ready = 0;
        out_ready = 1;
        drain(200);
        check("final_ops", ops_done, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
